// File: rtl/burst_pkg.sv
// rtl/burst_pkg.sv - shared widths and enum types for the burst memory responder
package burst_pkg;

  localparam int BEATS       = 4;
  localparam int BEAT_W      = 64;
  localparam int LINE_W      = 256;
  localparam int OFFSET_W    = 5;
  localparam int BEAT_IDX_W  = 2;
  localparam int LAT_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_TURN  = 2'd3
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/line_store.sv
// rtl/line_store.sv - flop-based line storage with per-beat write and combinational line read
module line_store
  import burst_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [BEAT_IDX_W-1:0] wr_beat_i,
  input  logic [BEAT_W-1:0]     wr_data_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [LINE_W-1:0]     rd_line_o
);

  localparam int LINES = 2 ** IDX_W;

  logic [LINE_W-1:0] mem_q [LINES];
  logic [LINE_W-1:0] mem_d [LINES];

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[wr_idx_i][wr_beat_i*BEAT_W +: BEAT_W] = wr_data_i;
    end
  end

  // Clear takes priority over a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_line_o = mem_q[rd_idx_i];

endmodule

// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - fixed-latency 4-beat line read/write responder
module burst_mem_responder
  import burst_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o
);

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [BEAT_IDX_W-1:0]  beat_q, beat_d;
  logic [LINE_W-1:0]      snap_q, snap_d;
  logic [LINE_W-1:0]      rd_line;
  logic                   we;
  logic                   addr_unused;

  assign addr_unused = ^{address_i[31:OFFSET_W+IDX_W], address_i[OFFSET_W-1:0]};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    lat_cnt_d = lat_cnt_q;
    beat_d    = beat_q;
    snap_d    = snap_q;
    we        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        lat_cnt_d = '0;
        beat_d    = '0;
        if (read_i) begin
          op_d    = OP_READ;
          idx_d   = address_i[OFFSET_W +: IDX_W];
          state_d = ST_WAIT;
        end else if (write_i) begin
          op_d    = OP_WRITE;
          idx_d   = address_i[OFFSET_W +: IDX_W];
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Snapshot on the way out so read data is stable for the whole burst.
        if (lat_cnt_q == LAT_CNT_W'(LATENCY - 1)) begin
          lat_cnt_d = '0;
          beat_d    = '0;
          snap_d    = rd_line;
          state_d   = ST_BURST;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      ST_BURST: begin
        we     = (op_q == OP_WRITE);
        beat_d = beat_q + 1'b1;
        if (beat_q == BEAT_IDX_W'(BEATS - 1)) begin
          state_d = ST_TURN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_READ;
      idx_q     <= '0;
      lat_cnt_q <= '0;
      beat_q    <= '0;
      snap_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      lat_cnt_q <= lat_cnt_d;
      beat_q    <= beat_d;
      snap_q    <= snap_d;
    end
  end

  line_store #(
    .IDX_W (IDX_W)
  ) u_line_store (
    .clk       (clk),
    .rst       (rst),
    .wr_idx_i  (idx_q),
    .wr_beat_i (beat_q),
    .wr_data_i (burst_i),
    .we_i      (we),
    .rd_idx_i  (idx_q),
    .rd_line_o (rd_line)
  );

  assign resp_o  = (state_q == ST_BURST);
  assign burst_o = (state_q == ST_BURST && op_q == OP_READ) ?
                   snap_q[beat_q*BEAT_W +: BEAT_W] : '0;

endmodule

// File: tb/tb_burst_mem_responder.sv
// tb/tb_burst_mem_responder.sv - randomized self-checking bench with a line-array reference model
module tb_burst_mem_responder;

  localparam int LATENCY = 3;
  localparam int IDX_W   = 4;
  localparam int LINES   = 2 ** IDX_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] address_i = '0;
  logic        read_i = 1'b0;
  logic        write_i = 1'b0;
  logic [63:0] burst_i = '0;
  logic [63:0] burst_o;
  logic        resp_o;

  logic [255:0] model [LINES];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  burst_mem_responder #(
    .LATENCY (LATENCY),
    .IDX_W   (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .resp_o    (resp_o)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32) % LINES);
  endfunction

  // Entered at the negedge of an IDLE cycle; the following posedge accepts.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wline, input int drop_at,
                         input bit hold_turn, input bit rst_beat2);
    int           idx;
    logic [255:0] exp_line;
    bit           stop;
    idx      = idx_of(addr);
    exp_line = model[idx];
    stop     = 1'b0;
    read_i    = rd;
    write_i   = wr;
    address_i = addr;
    for (int c = 1; c <= LATENCY; c++) begin
      @(negedge clk);
      check_val("wait_resp", resp_o, 0);
      check_val("wait_data", burst_o, 0);
      address_i = $urandom;
    end
    for (int k = 0; k < 4 && !stop; k++) begin
      @(negedge clk);
      check_val("beat_resp", resp_o, 1);
      check_val(rd ? "read_beat" : "write_beat_data", burst_o, rd ? exp_line[k*64 +: 64] : 64'h0);
      burst_i = wline[k*64 +: 64];
      if (k >= drop_at) begin
        read_i  = 1'b0;
        write_i = 1'b0;
      end
      if (rst_beat2 && k == 2) begin
        rst  = 1'b1;
        stop = 1'b1;
      end
    end
    if (rst_beat2) begin
      @(negedge clk);
      check_val("rst_resp", resp_o, 0);
      check_val("rst_data", burst_o, 0);
      rst     = 1'b0;
      read_i  = 1'b0;
      write_i = 1'b0;
      for (int i = 0; i < LINES; i++) model[i] = '0;
      repeat (LATENCY + 4) begin
        @(negedge clk);
        check_val("post_rst_resp", resp_o, 0);
      end
    end else begin
      if (!rd) model[idx] = wline;
      @(negedge clk);
      check_val("turn_resp", resp_o, 0);
      check_val("turn_data", burst_o, 0);
      if (!hold_turn) begin
        read_i  = 1'b0;
        write_i = 1'b0;
      end
      @(negedge clk);
      check_val("idle_resp", resp_o, 0);
      check_val("idle_data", burst_o, 0);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    logic [255:0] pat;
    bit rd, both;
    for (int i = 0; i < LINES; i++) model[i] = '0;
    pat = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

    repeat (3) @(negedge clk);
    check_val("reset_resp", resp_o, 0);
    check_val("reset_data", burst_o, 0);
    rst = 1'b0;
    run_txn(1, 0, 32'h0000_0040, '0, 4, 0, 0);

    run_txn(0, 1, 32'h0000_0040, pat, 4, 0, 0);
    run_txn(1, 0, 32'h0000_0040, '0, 4, 0, 0);
    run_txn(1, 0, 32'h0000_0060, '0, 4, 0, 0);

    run_txn(1, 1, 32'h0000_0080, rand_line(), 4, 0, 0);
    run_txn(1, 0, 32'h0000_0080, '0, 4, 0, 0);

    run_txn(1, 0, 32'h0000_0040, '0, 4, 1, 0);
    run_txn(1, 0, 32'h0000_0040, '0, 4, 0, 0);

    run_txn(0, 1, 32'h0000_0060, rand_line(), 2, 0, 0);
    run_txn(1, 0, 32'h0000_0060, '0, 4, 0, 0);

    run_txn(0, 1, 32'h0000_0040, rand_line(), 4, 0, 1);
    run_txn(1, 0, 32'h0000_0040, '0, 4, 0, 0);
    run_txn(1, 0, 32'h0000_0060, '0, 4, 0, 0);

    run_txn(0, 1, 32'h0000_0040, pat, 4, 0, 0);
    run_txn(1, 0, 32'h0000_0245, '0, 4, 0, 0);

    for (int t = 0; t < 48; t++) begin
      rd   = bit'($urandom_range(0, 1));
      both = ($urandom_range(0, 7) == 0);
      run_txn(rd | both, !rd | both, $urandom, rand_line(),
              $urandom_range(0, 4), bit'($urandom_range(0, 1)), 0);
    end
    read_i  = 1'b0;
    write_i = 1'b0;
    for (int i = 0; i < LINES; i++) begin
      run_txn(1, 0, 32'(i * 32), '0, 4, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
